zspi_kbdmus: RTL and testbench

SPI-slave front end that receives keyboard-matrix, mouse and Kempston-joystick packets from the board AVR and converts them into parallel data plus single-cycle strobes in the fclk domain. It sits directly upstream of the Z80 port multiplexer for keyboard, mouse and joystick, and drives that block's key, mouse and joystick load interface.

---
 rtl/zspi_kbdmus.sv | 177 +++++++++++++++++
 tb/tb_zspi_kbdmus.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/zspi_kbdmus.sv
// zspi_kbdmus: SPI-slave receiver for keyboard-matrix, mouse and Kempston-joystick
// packets from the board AVR. It produces parallel data plus one-cycle strobes in
// the fclk domain.
// Optional feature: define ZSPI_MISO_ECHO_EN to echo the last completed byte of the
// previous transaction on spido. When the macro is not defined, spido is tied to 1.
module zspi_kbdmus (
  input  logic        fclk,
  input  logic        rst,
  input  logic        spick,
  input  logic        spics_n,
  input  logic        spidi,
  output logic        spido,
  output logic [39:0] kbd_out,
  output logic        kbd_stb,
  output logic [7:0]  mus_out,
  output logic        mus_xstb,
  output logic        mus_ystb,
  output logic        mus_btnstb,
  output logic        kj_stb
);

  typedef enum logic [2:0] {StIdle, StCmd, StKbd, StMbyte, StSkip} state_t;

  // Mouse/joystick command codes, latched during CMD
  typedef enum logic [1:0] {MusX, MusY, MusBtn, MusKj} mcmd_t;

  logic [2:0] ck_s;   // [1:0] synchronizer, [2] edge-detect history
  logic [2:0] cs_s;
  logic [1:0] di_s;

  state_t      state;
  mcmd_t       mcmd;
  logic [2:0]  bit_cnt;
  logic [2:0]  byte_cnt;
  logic [6:0]  sr;       // bits already received in the current byte
  logic [31:0] shadow;   // keyboard bytes 0..3; byte 4 goes straight to kbd_out

  logic       ck_rise;
  logic       cs_fall;
  logic       cs_rise;
  logic       byte_done;
  logic [7:0] rx_byte;

  // Synchronize the asynchronous SPI pins and keep one extra stage for edge detection
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      ck_s <= 3'b000;
      cs_s <= 3'b111;
      di_s <= 2'b00;
    end else begin
      ck_s <= {ck_s[1:0], spick};
      cs_s <= {cs_s[1:0], spics_n};
      di_s <= {di_s[0], spidi};
    end
  end

  // Edge decode. A chip-select edge masks a spick edge that arrives in the same cycle.
  always_comb begin
    ck_rise   = ck_s[1] & ~ck_s[2];
    cs_fall   = ~cs_s[1] & cs_s[2];
    cs_rise   = cs_s[1] & ~cs_s[2];
    rx_byte   = {sr, di_s[1]};
    byte_done = ck_rise & ~cs_rise & ~cs_fall & (state != StIdle) & (bit_cnt == 3'd7);
  end

  // Receive FSM. It owns the counters, the shadow, the data outputs and the strobes.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      mcmd       <= MusX;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 3'd0;
      sr         <= 7'd0;
      shadow     <= 32'd0;
      kbd_out    <= 40'd0;
      mus_out    <= 8'd0;
      kbd_stb    <= 1'b0;
      mus_xstb   <= 1'b0;
      mus_ystb   <= 1'b0;
      mus_btnstb <= 1'b0;
      kj_stb     <= 1'b0;
    end else begin
      kbd_stb    <= 1'b0;
      mus_xstb   <= 1'b0;
      mus_ystb   <= 1'b0;
      mus_btnstb <= 1'b0;
      kj_stb     <= 1'b0;
      if (cs_rise) begin
        state    <= StIdle;
        bit_cnt  <= 3'd0;
        byte_cnt <= 3'd0;
      end else if (cs_fall) begin
        state    <= StCmd;
        bit_cnt  <= 3'd0;
        byte_cnt <= 3'd0;
        shadow   <= 32'd0;
      end else if (ck_rise && state != StIdle) begin
        sr      <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          unique case (state)
            StCmd: begin
              byte_cnt <= 3'd0;
              case (rx_byte)
                8'h10:   state <= StKbd;
                8'h20:   begin mcmd <= MusX;   state <= StMbyte; end
                8'h21:   begin mcmd <= MusY;   state <= StMbyte; end
                8'h22:   begin mcmd <= MusBtn; state <= StMbyte; end
                8'h30:   begin mcmd <= MusKj;  state <= StMbyte; end
                default: state <= StSkip;
              endcase
            end
            StKbd: begin
              case (byte_cnt)
                3'd0:    shadow[7:0]   <= rx_byte;
                3'd1:    shadow[15:8]  <= rx_byte;
                3'd2:    shadow[23:16] <= rx_byte;
                3'd3:    shadow[31:24] <= rx_byte;
                default: ;
              endcase
              if (byte_cnt == 3'd4) begin
                kbd_out <= {rx_byte, shadow};
                kbd_stb <= 1'b1;
                state   <= StSkip;
              end else begin
                byte_cnt <= byte_cnt + 3'd1;
              end
            end
            StMbyte: begin
              mus_out <= rx_byte;
              unique case (mcmd)
                MusX:   mus_xstb   <= 1'b1;
                MusY:   mus_ystb   <= 1'b1;
                MusBtn: mus_btnstb <= 1'b1;
                MusKj:  kj_stb     <= 1'b1;
              endcase
              state <= StSkip;
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef ZSPI_MISO_ECHO_EN
  logic [7:0] last_byte;  // last completed byte in any transaction
  logic [6:0] tx_sr;      // remaining echo bits; ones shift in behind them
  logic       ck_fall;

  always_comb ck_fall = ~ck_s[1] & ck_s[2];

  // MISO echo: load at CS fall, then shift on each spick fall, MSB first
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      last_byte <= 8'hFF;
      tx_sr     <= 7'h7F;
      spido     <= 1'b1;
    end else begin
      if (byte_done) last_byte <= rx_byte;
      if (cs_rise) begin
        spido <= 1'b1;
        tx_sr <= 7'h7F;
      end else if (cs_fall) begin
        spido <= last_byte[7];
        tx_sr <= last_byte[6:0];
      end else if (ck_fall && state != StIdle) begin
        spido <= tx_sr[6];
        tx_sr <= {tx_sr[5:0], 1'b1};
      end
    end
  end
`else
  assign spido = 1'b1;
`endif

endmodule

// File: tb/tb_zspi_kbdmus.sv
// tb_zspi_kbdmus: scoreboard bench for zspi_kbdmus. Each transaction pushes the
// strobe it should cause. A monitor process pops that entry and compares it on every
// strobe, including the latency from the 8th spick rise.
module tb_zspi_kbdmus;
  logic        fclk = 1'b0;
  logic        rst, spick, spics_n, spidi;
  logic        spido;
  logic [39:0] kbd_out;
  logic        kbd_stb;
  logic [7:0]  mus_out;
  logic        mus_xstb, mus_ystb, mus_btnstb, kj_stb;

  zspi_kbdmus dut (
    .fclk       (fclk),
    .rst        (rst),
    .spick      (spick),
    .spics_n    (spics_n),
    .spidi      (spidi),
    .spido      (spido),
    .kbd_out    (kbd_out),
    .kbd_stb    (kbd_stb),
    .mus_out    (mus_out),
    .mus_xstb   (mus_xstb),
    .mus_ystb   (mus_ystb),
    .mus_btnstb (mus_btnstb),
    .kj_stb     (kj_stb)
  );

  always #5 fclk = ~fclk;

  // kind: 0 kbd, 1 mouse X, 2 mouse Y, 3 buttons, 4 joystick
  typedef struct {
    int          kind;
    logic [39:0] val;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  time        last_rise = 0;
  logic [7:0] exp_echo;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Strobe monitor: sampled on the falling fclk edge
  exp_t mon_e;
  int   mon_n;
  int   mon_kind;
  logic [39:0] mon_val;
  always @(negedge fclk) begin
    if (!rst) begin
      mon_n = $countones({kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb});
      if (mon_n != 0) begin
        total++;
        mon_kind = kbd_stb ? 0 : mus_xstb ? 1 : mus_ystb ? 2 : mus_btnstb ? 3 : 4;
        mon_val  = kbd_stb ? kbd_out : {32'd0, mus_out};
        if (mon_n > 1) begin
          bad++;
          $display("FAIL multi_strobe got=%0d strobes exp=1", mon_n);
        end else if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe got kind=%0d val=%h exp=none", mon_kind, mon_val);
        end else begin
          mon_e = q.pop_front();
          if (mon_kind != mon_e.kind || mon_val !== mon_e.val || ($time - last_rise) != 30) begin
            bad++;
            $display("FAIL strobe got kind=%0d val=%h lat=%0t exp kind=%0d val=%h lat=30",
                     mon_kind, mon_val, $time - last_rise, mon_e.kind, mon_e.val);
          end
        end
      end
    end
  end

  // Sends n whole bytes from d (MSB byte first), then part bits of the next byte.
  // It also checks the first byte read back on spido.
  task automatic xfer(input logic [63:0] d, input int n, input int part, input bit keep_cs);
    logic [7:0] rx;
    logic [7:0] b;
    int         nb;
    rx = 8'h00;
    spics_n = 1'b0;
    repeat (6) @(negedge fclk);
    for (int i = 0; i < n + ((part > 0) ? 1 : 0); i++) begin
      b  = d[63 - 8*i -: 8];
      nb = (i < n) ? 8 : part;
      for (int j = 0; j < nb; j++) begin
        spidi = b[7 - j];
        repeat (5) @(negedge fclk);
        if (i == 0) rx[7 - j] = spido;
        spick = 1'b1;
        last_rise = $time;
        repeat (5) @(negedge fclk);
        spick = 1'b0;
      end
    end
    if (n > 0) chk("miso_first_byte", {32'd0, rx}, {32'd0, exp_echo});
`ifdef ZSPI_MISO_ECHO_EN
    if (n > 0) exp_echo = d[63 - 8*(n-1) -: 8];
`endif
    repeat (5) @(negedge fclk);
    if (!keep_cs) spics_n = 1'b1;
    repeat (6) @(negedge fclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; spick = 1'b0; spics_n = 1'b1; spidi = 1'b0;
    exp_echo = 8'hFF;
    repeat (3) @(negedge fclk);
    chk("rst_kbd_out", kbd_out, 40'd0);
    chk("rst_mus_out", {32'd0, mus_out}, 40'd0);
    chk("rst_strobes", {35'd0, kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb}, 40'd0);
    chk("rst_spido", {39'd0, spido}, 40'd1);
    rst = 1'b0;
    repeat (5) @(negedge fclk);

    // Keyboard frame
    q.push_back('{0, 40'h80_0000_0001});
    xfer(64'h10_01_00_00_00_80_00_00, 6, 0, 1'b0);
    chk("kbd_frame", kbd_out, 40'h80_0000_0001);

    // Mouse and joystick
    q.push_back('{1, 40'h05});
    xfer(64'h20_05_00_00_00_00_00_00, 2, 0, 1'b0);
    q.push_back('{2, 40'hFB});
    xfer(64'h21_FB_00_00_00_00_00_00, 2, 0, 1'b0);
    q.push_back('{3, 40'h07});
    xfer(64'h22_07_00_00_00_00_00_00, 2, 0, 1'b0);
    q.push_back('{4, 40'h1F});
    xfer(64'h30_1F_00_00_00_00_00_00, 2, 0, 1'b0);
    chk("mus_hold", {32'd0, mus_out}, 40'h1F);
    chk("kbd_hold", kbd_out, 40'h80_0000_0001);

    // Abort partway through byte 3 of a keyboard frame
    xfer(64'h10_AA_55_C0_00_00_00_00, 3, 3, 1'b0);
    chk("abort_kbd_keep", kbd_out, 40'h80_0000_0001);
    q.push_back('{0, 40'h55_44_33_22_11});
    xfer(64'h10_11_22_33_44_55_00_00, 6, 0, 1'b0);
    chk("after_abort_kbd", kbd_out, 40'h55_44_33_22_11);

    // Unknown command and excess bytes
    xfer(64'h77_12_00_00_00_00_00_00, 2, 0, 1'b0);
    q.push_back('{1, 40'h11});
    xfer(64'h20_11_22_00_00_00_00_00, 3, 0, 1'b0);
    chk("excess_mus", {32'd0, mus_out}, 40'h11);

    // Echo source byte 0x3C, checked on the next transaction's first byte
    q.push_back('{4, 40'h3C});
    xfer(64'h30_3C_00_00_00_00_00_00, 2, 0, 1'b0);

    // Reset in the middle of a keyboard frame
    xfer(64'h10_01_02_00_00_00_00_00, 3, 0, 1'b1);
    @(negedge fclk);
    rst = 1'b1;
    #1;
    chk("midrst_kbd_out", kbd_out, 40'd0);
    chk("midrst_mus_out", {32'd0, mus_out}, 40'd0);
    chk("midrst_spido", {39'd0, spido}, 40'd1);
    exp_echo = 8'hFF;
    repeat (2) @(negedge fclk);
    rst = 1'b0;
    spics_n = 1'b1;
    repeat (6) @(negedge fclk);
    q.push_back('{0, 40'hE5_D4_C3_B2_A1});
    xfer(64'h10_A1_B2_C3_D4_E5_00_00, 6, 0, 1'b0);
    chk("after_rst_kbd", kbd_out, 40'hE5_D4_C3_B2_A1);

    repeat (20) @(negedge fclk);
    chk("queue_empty", 40'(q.size()), 40'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
